// File: rtl/mips_mult_div.sv
// Iterative MIPS HI/LO unit: MULT/MULTU/DIV/DIVU, one bit per clock.
// Signed operations run on magnitudes and the result signs are applied in a final FIXUP cycle.
module mips_mult_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic [WIDTH-1:0]  p_hi_q, p_hi_d;
  logic [WIDTH-1:0]  p_lo_q, p_lo_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  a_raw_q, a_raw_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              dbz_q, dbz_d;

  logic              sign_a_s, sign_b_s;
  logic [WIDTH:0]    sum_s;
  logic [WIDTH:0]    rsh_s;
  logic [WIDTH:0]    diff_s;
  logic [2*WIDTH-1:0] prod_s;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign sign_a_s = op[0] & operand_a[WIDTH-1];
  assign sign_b_s = op[0] & operand_b[WIDTH-1];

  // Multiply step adds the multiplicand into the high half when the next multiplier bit is set.
  assign sum_s  = {1'b0, p_hi_q} + {1'b0, (p_lo_q[0] ? mcand_q : {WIDTH{1'b0}})};
  // Divide step: the partial remainder stays below the divisor, so the trial difference fits in WIDTH bits.
  assign rsh_s  = {p_hi_q, p_lo_q[WIDTH-1]};
  assign diff_s = rsh_s - {1'b0, mcand_q};
  assign prod_s = {p_hi_q, p_lo_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    p_hi_d    = p_hi_q;
    p_lo_d    = p_lo_q;
    mcand_d   = mcand_q;
    a_raw_d   = a_raw_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d  = op[1];
          a_raw_d   = operand_a;
          neg_res_d = sign_a_s ^ sign_b_s;
          neg_rem_d = sign_a_s;
          p_hi_d    = {WIDTH{1'b0}};
          // The divider shifts the dividend out of LO; the multiplier shifts the multiplier out of LO.
          if (op[1]) begin
            p_lo_d  = sign_a_s ? neg_w(operand_a) : operand_a;
            mcand_d = sign_b_s ? neg_w(operand_b) : operand_b;
          end else begin
            p_lo_d  = sign_b_s ? neg_w(operand_b) : operand_b;
            mcand_d = sign_a_s ? neg_w(operand_a) : operand_a;
          end
          cnt_d   = CW'(WIDTH - 1);
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (is_div_q) begin
          if (!diff_s[WIDTH]) begin
            p_hi_d = diff_s[WIDTH-1:0];
            p_lo_d = {p_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            p_hi_d = rsh_s[WIDTH-1:0];
            p_lo_d = {p_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          {p_hi_d, p_lo_d} = {sum_s, p_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == {CW{1'b0}}) begin
          state_d = FIXUP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIXUP: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
        if (is_div_q) begin
          if (mcand_q == {WIDTH{1'b0}}) begin
            dbz_d = 1'b1;
            hi_d  = a_raw_q;
            lo_d  = {WIDTH{1'b1}};
          end else begin
            dbz_d = 1'b0;
            hi_d  = neg_rem_q ? neg_w(p_hi_q) : p_hi_q;
            lo_d  = neg_res_q ? neg_w(p_lo_q) : p_lo_q;
          end
        end else begin
          dbz_d        = 1'b0;
          {hi_d, lo_d} = neg_res_q ? neg_2w(prod_s) : prod_s;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      is_div_q  <= 1'b0;
      p_hi_q    <= {WIDTH{1'b0}};
      p_lo_q    <= {WIDTH{1'b0}};
      mcand_q   <= {WIDTH{1'b0}};
      a_raw_q   <= {WIDTH{1'b0}};
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      p_hi_q    <= p_hi_d;
      p_lo_q    <= p_lo_d;
      mcand_q   <= mcand_d;
      a_raw_q   <= a_raw_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
